// File: rtl/bcd_updown_counter_n.sv
// Multi-digit BCD up/down counter with step prescaler,
// parallel load and wrap/saturate handling at the limits.
module bcd_updown_counter_n #(
  parameter int DIGITS  = 2,
  parameter int CLK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  direction,
  input  logic                  sat_mode,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  at_limit,
  output logic                  tc
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [W-1:0]  r_count;
  logic [PW-1:0] r_pre;
  logic          r_tc;

  logic [W-1:0]  w_next;
  logic [W-1:0]  w_load;
  logic [3:0]    w_d;
  logic [3:0]    w_ld;
  logic          w_max;
  logic          w_min;
  logic          w_carry;
  logic          w_step;
  logic          w_hold;

  // One ripple pass: carry/borrow flows from digit 0 upward
  always_comb begin
    w_next  = '0;
    w_load  = '0;
    w_d     = '0;
    w_ld    = '0;
    w_max   = 1'b1;
    w_min   = 1'b1;
    w_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_d   = r_count[4*i +: 4];
      w_max = w_max & (w_d == 4'd9);
      w_min = w_min & (w_d == 4'd0);
      if (!w_carry) begin
        w_next[4*i +: 4] = w_d;
      end else if (direction) begin
        if (w_d == 4'd9) begin
          w_next[4*i +: 4] = 4'd0;
        end else begin
          w_next[4*i +: 4] = w_d + 4'd1;
          w_carry          = 1'b0;
        end
      end else begin
        if (w_d == 4'd0) begin
          w_next[4*i +: 4] = 4'd9;
        end else begin
          w_next[4*i +: 4] = w_d - 4'd1;
          w_carry          = 1'b0;
        end
      end
      w_ld = load_val[4*i +: 4];
      w_load[4*i +: 4] = (w_ld > 4'd9) ? 4'd9 : w_ld;
    end
  end

  assign at_limit = direction ? w_max : w_min;
  assign w_step   = enable & (r_pre == PRE_LAST);
  assign w_hold   = at_limit & sat_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_pre   <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= w_load;
      r_pre   <= '0;
      r_tc    <= 1'b0;
    end else if (w_step) begin
      r_pre <= '0;
      r_tc  <= at_limit;
      if (!w_hold) begin
        r_count <= w_next;
      end
    end else if (enable) begin
      r_pre <= r_pre + 1'b1;
      r_tc  <= 1'b0;
    end else begin
      r_tc  <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Scoreboard bench: two DUTs (CLK_DIV=1 and 4) share stimulus,
// an integer reference model queues expected outputs per cycle.
module tb_bcd_updown_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       direction = 1'b0;
  logic       sat_mode = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] c1, c4;
  logic       al1, al4, tc1, tc4;

  bcd_updown_counter_n #(.DIGITS(2), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable),
    .direction(direction), .sat_mode(sat_mode),
    .load(load), .load_val(load_val),
    .count(c1), .at_limit(al1), .tc(tc1)
  );

  bcd_updown_counter_n #(.DIGITS(2), .CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable),
    .direction(direction), .sat_mode(sat_mode),
    .load(load), .load_val(load_val),
    .count(c4), .at_limit(al4), .tc(tc4)
  );

  typedef struct packed {
    logic [7:0] c;
    logic       al;
    logic       tc;
  } exp_t;

  typedef struct packed {
    logic       r;
    logic       ld;
    logic       en;
    logic       dir;
    logic       sat;
    logic [7:0] lv;
  } stim_t;

  exp_t q[2][$];
  exp_t obs[2];
  int   m_cnt[2];
  int   m_pre[2];
  logic m_tc[2];
  int   div[2] = '{1, 4};
  int   vectors = 0;
  int   errors = 0;

  always_comb begin
    obs[0] = {c1, al1, tc1};
    obs[1] = {c4, al4, tc4};
  end

  function automatic stim_t s(logic r, logic ld, logic en,
                              logic dir, logic sat, logic [7:0] lv);
    s = {r, ld, en, dir, sat, lv};
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // Drive one cycle: update the decimal model, queue expectations, clock
  task automatic tick(stim_t v);
    int hi, lo;
    bit lim;
    rst = v.r; load = v.ld; enable = v.en;
    direction = v.dir; sat_mode = v.sat; load_val = v.lv;
    for (int k = 0; k < 2; k++) begin
      lim = v.dir ? (m_cnt[k] == 99) : (m_cnt[k] == 0);
      if (v.r) begin
        m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 1'b0;
      end else if (v.ld) begin
        hi = (v.lv[7:4] > 9) ? 9 : int'(v.lv[7:4]);
        lo = (v.lv[3:0] > 9) ? 9 : int'(v.lv[3:0]);
        m_cnt[k] = hi * 10 + lo; m_pre[k] = 0; m_tc[k] = 1'b0;
      end else if (v.en && m_pre[k] == div[k] - 1) begin
        m_pre[k] = 0;
        m_tc[k] = lim;
        if (!(lim && v.sat))
          m_cnt[k] = v.dir ? (m_cnt[k] + 1) % 100 : (m_cnt[k] + 99) % 100;
      end else begin
        if (v.en) m_pre[k] = m_pre[k] + 1;
        m_tc[k] = 1'b0;
      end
      lim = v.dir ? (m_cnt[k] == 99) : (m_cnt[k] == 0);
      q[k].push_back({to_bcd(m_cnt[k]), lim, m_tc[k]});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t v[$];
    exp_t e;
    v = '{s(1,0,0,0,0,8'h00), s(1,0,0,0,0,8'h00),
          s(1,0,1,0,0,8'h77), s(1,1,1,1,0,8'h42)};
    foreach (v[i]) begin
      tick(v[i]);
      for (int k = 0; k < 2; k++) begin
        e = q[k].pop_front();
        vectors++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL reset[%0d] dut%0d: got c=%h al=%b tc=%b want c=%h al=%b tc=%b",
                   i, k, obs[k].c, obs[k].al, obs[k].tc, e.c, e.al, e.tc);
        end
      end
    end
  endtask

  task automatic test_count_up();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      tick(s(0,0,1,1,0,8'h00));
      for (int k = 0; k < 2; k++) begin
        e = q[k].pop_front();
        vectors++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL count_up[%0d] dut%0d: got c=%h al=%b tc=%b want c=%h al=%b tc=%b",
                   i, k, obs[k].c, obs[k].al, obs[k].tc, e.c, e.al, e.tc);
        end
      end
    end
  endtask

  task automatic test_wrap_up();
    stim_t v[$];
    exp_t e;
    v = '{s(0,1,1,1,0,8'h98), s(0,0,1,1,0,8'h00), s(0,0,1,1,0,8'h00),
          s(0,0,1,1,0,8'h00), s(0,0,1,1,0,8'h00)};
    foreach (v[i]) begin
      tick(v[i]);
      for (int k = 0; k < 2; k++) begin
        e = q[k].pop_front();
        vectors++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL wrap_up[%0d] dut%0d: got c=%h al=%b tc=%b want c=%h al=%b tc=%b",
                   i, k, obs[k].c, obs[k].al, obs[k].tc, e.c, e.al, e.tc);
        end
      end
    end
  endtask

  task automatic test_saturate();
    stim_t v[$];
    exp_t e;
    v = '{s(0,1,1,1,1,8'h98), s(0,0,1,1,1,8'h00), s(0,0,1,1,1,8'h00),
          s(0,0,1,1,1,8'h00), s(0,0,1,1,1,8'h00), s(0,0,1,0,1,8'h00),
          s(0,0,0,0,1,8'h00)};
    foreach (v[i]) begin
      tick(v[i]);
      for (int k = 0; k < 2; k++) begin
        e = q[k].pop_front();
        vectors++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL saturate[%0d] dut%0d: got c=%h al=%b tc=%b want c=%h al=%b tc=%b",
                   i, k, obs[k].c, obs[k].al, obs[k].tc, e.c, e.al, e.tc);
        end
      end
    end
  endtask

  task automatic test_prescale();
    stim_t v[$];
    exp_t e;
    v.push_back(s(1,0,0,1,0,8'h00));
    repeat (6) v.push_back(s(0,0,1,1,0,8'h00));
    repeat (5) v.push_back(s(0,0,0,0,0,8'h00));
    repeat (4) v.push_back(s(0,0,1,1,0,8'h00));
    foreach (v[i]) begin
      tick(v[i]);
      for (int k = 0; k < 2; k++) begin
        e = q[k].pop_front();
        vectors++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL prescale[%0d] dut%0d: got c=%h al=%b tc=%b want c=%h al=%b tc=%b",
                   i, k, obs[k].c, obs[k].al, obs[k].tc, e.c, e.al, e.tc);
        end
      end
    end
  endtask

  task automatic test_clamp_wrap_down();
    stim_t v[$];
    exp_t e;
    v = '{s(0,1,0,1,0,8'h3C), s(0,1,0,1,0,8'hAF), s(0,1,0,0,0,8'h00)};
    repeat (6) v.push_back(s(0,0,1,0,0,8'h00));
    foreach (v[i]) begin
      tick(v[i]);
      for (int k = 0; k < 2; k++) begin
        e = q[k].pop_front();
        vectors++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL clamp_wrap_down[%0d] dut%0d: got c=%h al=%b tc=%b want c=%h al=%b tc=%b",
                   i, k, obs[k].c, obs[k].al, obs[k].tc, e.c, e.al, e.tc);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t v[$];
    exp_t e;
    v.push_back(s(0,1,0,1,0,8'h20));
    repeat (6) v.push_back(s(0,0,1,1,0,8'h00));
    v.push_back(s(1,1,1,1,0,8'h55));
    repeat (9) v.push_back(s(0,0,1,1,0,8'h00));
    foreach (v[i]) begin
      tick(v[i]);
      for (int k = 0; k < 2; k++) begin
        e = q[k].pop_front();
        vectors++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL reset_mid[%0d] dut%0d: got c=%h al=%b tc=%b want c=%h al=%b tc=%b",
                   i, k, obs[k].c, obs[k].al, obs[k].tc, e.c, e.al, e.tc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int r;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 15));
      tick(s(r == 0, r == 1, r > 3, r[0], r[1], 8'($urandom)));
      for (int k = 0; k < 2; k++) begin
        e = q[k].pop_front();
        vectors++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL back_to_back[%0d] dut%0d: got c=%h al=%b tc=%b want c=%h al=%b tc=%b",
                   i, k, obs[k].c, obs[k].al, obs[k].tc, e.c, e.al, e.tc);
        end
      end
    end
  endtask

  initial begin
    m_cnt = '{0, 0};
    m_pre = '{0, 0};
    m_tc  = '{1'b0, 1'b0};
    test_reset();
    test_count_up();
    test_wrap_up();
    test_saturate();
    test_prescale();
    test_clamp_wrap_down();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
